// File: rtl/pc_redirect_pkg.sv
// Shared types and constants for the fetch-side PC redirect unit.
package pc_redirect_pkg;

  localparam int ADDR_W  = 32;
  localparam int COUNT_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t PC_INCR              = 32'd4;
  localparam addr_t RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    PEND = 2'd3
  } state_e;

  // Branch targets are word aligned; the low two bits are dropped on load.
  function automatic addr_t alignTarget(input addr_t target);
    return target & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/redirect_counter.sv
// Free-running wrapping event counter used for redirect statistics.
module redirect_counter
  import pc_redirect_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               inc_i,
  output logic [COUNT_W-1:0] count_o
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch-side PC owner: redirects on EX branches, sequences against IMEM stalls and HOLD.
// Define PC_REDIRECT_STATS_EN to add the REDIRECT_COUNT statistics output.
module pc_redirect_unit
  import pc_redirect_pkg::*;
#(
  parameter addr_t RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        PC_MUX_OUT,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        EX_VALID,
  input  logic        HOLD,
  input  logic        IMEM_BUSY,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS_4,
  output logic        IMEM_READ,
  output logic        FLUSH
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0] REDIRECT_COUNT
`endif
);

  state_e state_q;
  state_e state_d;
  addr_t  pc_q;
  addr_t  pc_d;
  addr_t  latchedTarget_q;
  addr_t  latchedTarget_d;

  logic   taken;
  addr_t  alignedTarget;

  assign taken         = PC_MUX_OUT & EX_VALID;
  assign alignedTarget = alignTarget(BRANCH_TARGET);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q         <= BOOT;
      pc_q            <= RESET_VECTOR;
      latchedTarget_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      latchedTarget_q <= latchedTarget_d;
    end
  end

  // Redirect beats memory stall, which beats HOLD, which beats sequential advance.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    latchedTarget_d = latchedTarget_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (taken) begin
          if (IMEM_BUSY) begin
            latchedTarget_d = alignedTarget;
            state_d         = PEND;
          end else begin
            pc_d = alignedTarget;
          end
        end else if (IMEM_BUSY) begin
          state_d = WAIT;
        end else if (!HOLD) begin
          pc_d = pc_q + PC_INCR;
        end
      end
      WAIT: begin
        if (taken) begin
          if (IMEM_BUSY) begin
            latchedTarget_d = alignedTarget;
            state_d         = PEND;
          end else begin
            pc_d    = alignedTarget;
            state_d = RUN;
          end
        end else if (!IMEM_BUSY) begin
          // The held fetch completes on this edge, so PC is not advanced yet.
          state_d = RUN;
        end
      end
      PEND: begin
        if (!IMEM_BUSY) begin
          pc_d    = latchedTarget_q;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    IMEM_READ = 1'b1;
    FLUSH     = 1'b0;
    unique case (state_q)
      BOOT: begin
        IMEM_READ = 1'b0;
        FLUSH     = 1'b1;
      end
      RUN, WAIT: begin
        FLUSH = taken;
      end
      PEND: begin
        FLUSH = 1'b1;
      end
      default: begin
        IMEM_READ = 1'b0;
        FLUSH     = 1'b1;
      end
    endcase
  end

  assign PC        = pc_q;
  assign PC_PLUS_4 = pc_q + PC_INCR;

`ifdef PC_REDIRECT_STATS_EN
  logic redirectAccept;

  assign redirectAccept = taken & ((state_q == RUN) | (state_q == WAIT));

  redirect_counter u_redirect_counter (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .inc_i   (redirectAccept),
    .count_o (REDIRECT_COUNT)
  );
`else
  // Statistics disabled: no counter hardware is built.
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios plus randomized run against a flag-level model.
module tb_pc_redirect_unit;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        PC_MUX_OUT = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0;
  logic        EX_VALID = 1'b0;
  logic        HOLD = 1'b0;
  logic        IMEM_BUSY = 1'b0;
  logic [31:0] PC;
  logic [31:0] PC_PLUS_4;
  logic        IMEM_READ;
  logic        FLUSH;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] REDIRECT_COUNT;
`endif

  int checks   = 0;
  int failures = 0;

  pc_redirect_unit #(
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .PC_MUX_OUT    (PC_MUX_OUT),
    .BRANCH_TARGET (BRANCH_TARGET),
    .EX_VALID      (EX_VALID),
    .HOLD          (HOLD),
    .IMEM_BUSY     (IMEM_BUSY),
    .PC            (PC),
    .PC_PLUS_4     (PC_PLUS_4),
    .IMEM_READ     (IMEM_READ),
    .FLUSH         (FLUSH)
`ifdef PC_REDIRECT_STATS_EN
    ,
    .REDIRECT_COUNT (REDIRECT_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference model in terms of "booting", "redirect pending" and "fetch stalled" flags.
  logic [31:0] mPc;
  bit          mBooting;
  bit          mRedirectPending;
  logic [31:0] mPendingTarget;
  bit          mFetchStalled;
  logic [31:0] mCount;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mPc = 32'h0; mBooting = 1'b1; mRedirectPending = 1'b0;
      mPendingTarget = 32'h0; mFetchStalled = 1'b0; mCount = 32'h0;
    end else if (mBooting) begin
      mBooting = 1'b0;
    end else if (mRedirectPending) begin
      if (!IMEM_BUSY) begin
        mPc = mPendingTarget;
        mRedirectPending = 1'b0;
      end
    end else if (PC_MUX_OUT && EX_VALID) begin
      mCount = mCount + 32'd1;
      mFetchStalled = 1'b0;
      if (IMEM_BUSY) begin
        mRedirectPending = 1'b1;
        mPendingTarget = {BRANCH_TARGET[31:2], 2'b00};
      end else begin
        mPc = {BRANCH_TARGET[31:2], 2'b00};
      end
    end else if (mFetchStalled) begin
      if (!IMEM_BUSY) mFetchStalled = 1'b0;
    end else if (IMEM_BUSY) begin
      mFetchStalled = 1'b1;
    end else if (!HOLD) begin
      mPc = mPc + 32'd4;
    end
  end

  task automatic applyStimulus(input bit mux, input logic [31:0] tgt, input bit exv,
                               input bit hold, input bit busy);
    PC_MUX_OUT = mux; BRANCH_TARGET = tgt; EX_VALID = exv; HOLD = hold; IMEM_BUSY = busy;
  endtask

  task automatic resetDut();
    @(negedge CLK);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge CLK);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    applyStimulus(1'b1, 32'h0000_0ABC, 1'b1, 1'b0, 1'b0);
    #3;
    checks++; if (PC !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc actual=%h required=%h", PC, 32'h0); end
    checks++; if (PC_PLUS_4 !== 32'h4) begin failures++; $display("[TB] FAIL reset_pc_plus_4 actual=%h required=%h", PC_PLUS_4, 32'h4); end
    checks++; if (IMEM_READ !== 1'b0) begin failures++; $display("[TB] FAIL reset_imem_read actual=%b required=0", IMEM_READ); end
    checks++; if (FLUSH !== 1'b1) begin failures++; $display("[TB] FAIL reset_flush actual=%b required=1", FLUSH); end
`ifdef PC_REDIRECT_STATS_EN
    checks++; if (REDIRECT_COUNT !== 32'h0) begin failures++; $display("[TB] FAIL reset_count actual=%0d required=0", REDIRECT_COUNT); end
`endif
  endtask

  task automatic test_boot_sequence();
    logic [31:0] expPc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    resetDut();
    #1;
    checks++; if (PC !== 32'h0 || IMEM_READ !== 1'b0 || FLUSH !== 1'b1) begin
      failures++; $display("[TB] FAIL boot_cycle actual pc=%h rd=%b fl=%b required pc=0 rd=0 fl=1", PC, IMEM_READ, FLUSH);
    end
    for (int i = 0; i < 4; i++) begin
      idleCycles(1);
      #1;
      checks++; if (PC !== expPc[i] || IMEM_READ !== 1'b1 || FLUSH !== 1'b0) begin
        failures++; $display("[TB] FAIL boot_run_%0d actual pc=%h rd=%b fl=%b required pc=%h rd=1 fl=0", i, PC, IMEM_READ, FLUSH, expPc[i]);
      end
    end
  endtask

  task automatic test_redirect_idle();
    resetDut();
    idleCycles(5);
    applyStimulus(1'b1, 32'h0000_0203, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (PC !== 32'h10 || FLUSH !== 1'b1) begin
      failures++; $display("[TB] FAIL redir_idle_taken actual pc=%h fl=%b required pc=10 fl=1", PC, FLUSH);
    end
    idleCycles(1);
    #1;
    checks++; if (PC !== 32'h200 || FLUSH !== 1'b0 || PC_PLUS_4 !== 32'h204) begin
      failures++; $display("[TB] FAIL redir_idle_target actual pc=%h fl=%b pc4=%h required pc=200 fl=0 pc4=204", PC, FLUSH, PC_PLUS_4);
    end
    idleCycles(1);
    #1;
    checks++; if (PC !== 32'h204) begin failures++; $display("[TB] FAIL redir_idle_next actual=%h required=204", PC); end
`ifdef PC_REDIRECT_STATS_EN
    checks++; if (REDIRECT_COUNT !== 32'd1) begin failures++; $display("[TB] FAIL redir_idle_count actual=%0d required=1", REDIRECT_COUNT); end
`endif
  endtask

  task automatic test_redirect_busy();
    resetDut();
    idleCycles(3);
    applyStimulus(1'b1, 32'h0000_0400, 1'b1, 1'b0, 1'b1);
    #1;
    checks++; if (PC !== 32'h8 || FLUSH !== 1'b1) begin
      failures++; $display("[TB] FAIL busy_c1 actual pc=%h fl=%b required pc=8 fl=1", PC, FLUSH);
    end
    @(negedge CLK);
    applyStimulus(1'b1, 32'h0000_0800, 1'b1, 1'b0, 1'b1);
    #1;
    checks++; if (PC !== 32'h8 || FLUSH !== 1'b1 || IMEM_READ !== 1'b1) begin
      failures++; $display("[TB] FAIL busy_c2 actual pc=%h fl=%b rd=%b required pc=8 fl=1 rd=1", PC, FLUSH, IMEM_READ);
    end
    @(negedge CLK);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (PC !== 32'h8 || FLUSH !== 1'b1) begin
      failures++; $display("[TB] FAIL busy_c3 actual pc=%h fl=%b required pc=8 fl=1", PC, FLUSH);
    end
    idleCycles(1);
    #1;
    checks++; if (PC !== 32'h8 || FLUSH !== 1'b1) begin
      failures++; $display("[TB] FAIL busy_release actual pc=%h fl=%b required pc=8 fl=1", PC, FLUSH);
    end
    idleCycles(1);
    #1;
    checks++; if (PC !== 32'h400 || FLUSH !== 1'b0) begin
      failures++; $display("[TB] FAIL busy_target actual pc=%h fl=%b required pc=400 fl=0", PC, FLUSH);
    end
`ifdef PC_REDIRECT_STATS_EN
    checks++; if (REDIRECT_COUNT !== 32'd1) begin failures++; $display("[TB] FAIL busy_count actual=%0d required=1", REDIRECT_COUNT); end
`endif
  endtask

  task automatic test_hold_ignore();
    resetDut();
    idleCycles(17);
    for (int i = 0; i < 2; i++) begin
      if (i != 0) @(negedge CLK);
      applyStimulus(1'b1, 32'h0000_0123, 1'b0, 1'b1, 1'b0);
      #1;
      checks++; if (PC !== 32'h40 || FLUSH !== 1'b0) begin
        failures++; $display("[TB] FAIL hold_c%0d actual pc=%h fl=%b required pc=40 fl=0", i, PC, FLUSH);
      end
    end
    idleCycles(1);
    #1;
    checks++; if (PC !== 32'h40) begin failures++; $display("[TB] FAIL hold_release actual=%h required=40", PC); end
    idleCycles(1);
    #1;
    checks++; if (PC !== 32'h44) begin failures++; $display("[TB] FAIL hold_advance actual=%h required=44", PC); end
  endtask

  task automatic test_wrap();
    resetDut();
    idleCycles(1);
    applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    idleCycles(1);
    #1;
    checks++; if (PC !== 32'hFFFF_FFFC || PC_PLUS_4 !== 32'h0) begin
      failures++; $display("[TB] FAIL wrap_top actual pc=%h pc4=%h required pc=fffffffc pc4=0", PC, PC_PLUS_4);
    end
    idleCycles(1);
    #1;
    checks++; if (PC !== 32'h0) begin failures++; $display("[TB] FAIL wrap_next actual=%h required=0", PC); end
  endtask

  task automatic test_reset_in_pend();
    resetDut();
    idleCycles(2);
    applyStimulus(1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b1);
    @(negedge CLK);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (FLUSH !== 1'b1) begin failures++; $display("[TB] FAIL pend_flush actual=%b required=1", FLUSH); end
    RESET_N = 1'b0;
    #1;
    checks++; if (PC !== 32'h0 || IMEM_READ !== 1'b0 || FLUSH !== 1'b1) begin
      failures++; $display("[TB] FAIL pend_async_reset actual pc=%h rd=%b fl=%b required pc=0 rd=0 fl=1", PC, IMEM_READ, FLUSH);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idleCycles(1);
    #1;
    checks++; if (PC !== 32'h0 || IMEM_READ !== 1'b1) begin
      failures++; $display("[TB] FAIL pend_first_fetch actual pc=%h rd=%b required pc=0 rd=1", PC, IMEM_READ);
    end
    idleCycles(1);
    #1;
    checks++; if (PC !== 32'h4) begin failures++; $display("[TB] FAIL pend_no_stale_target actual=%h required=4", PC); end
`ifdef PC_REDIRECT_STATS_EN
    checks++; if (REDIRECT_COUNT !== 32'd0) begin failures++; $display("[TB] FAIL pend_count_reset actual=%0d required=0", REDIRECT_COUNT); end
`endif
  endtask

  task automatic test_random();
    bit expRead;
    bit expFlush;
    resetDut();
    for (int i = 0; i < 600; i++) begin
      if (i != 0) @(negedge CLK);
      applyStimulus($urandom_range(0, 99) < 30, $urandom, $urandom_range(0, 99) < 70,
                    $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 30);
      #1;
      expRead  = !mBooting;
      expFlush = mBooting || mRedirectPending || (PC_MUX_OUT && EX_VALID);
      checks++; if (PC !== mPc) begin failures++; $display("[TB] FAIL rand_pc cyc=%0d actual=%h required=%h", i, PC, mPc); end
      checks++; if (PC_PLUS_4 !== mPc + 32'd4) begin failures++; $display("[TB] FAIL rand_pc4 cyc=%0d actual=%h required=%h", i, PC_PLUS_4, mPc + 32'd4); end
      checks++; if (IMEM_READ !== expRead) begin failures++; $display("[TB] FAIL rand_read cyc=%0d actual=%b required=%b", i, IMEM_READ, expRead); end
      checks++; if (FLUSH !== expFlush) begin failures++; $display("[TB] FAIL rand_flush cyc=%0d actual=%b required=%b", i, FLUSH, expFlush); end
`ifdef PC_REDIRECT_STATS_EN
      checks++; if (REDIRECT_COUNT !== mCount) begin failures++; $display("[TB] FAIL rand_count cyc=%0d actual=%0d required=%0d", i, REDIRECT_COUNT, mCount); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_boot_sequence();
    test_redirect_idle();
    test_redirect_busy();
    test_hold_ignore();
    test_wrap();
    test_reset_in_pend();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
